// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet FCS datapath (TX append, later RX check).
//   C_AXI_DATA_BYTES : bytes per AXI-Stream flit (the datapath is built for 32)
//   CRC_POLY         : reflected CRC-32 polynomial
//   CRC_INIT         : CRC register value at frame start
//   fcs_state_t      : PASS (normal flow) / EXTRA (spilled FCS flit pending)
//   crc32_byte()     : advance a reflected CRC-32 register by one byte, LSB first
package eth_pkg;

  localparam int          C_AXI_DATA_BYTES = 32;
  localparam logic [31:0] CRC_POLY         = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT         = 32'hFFFFFFFF;

  typedef enum logic {
    PASS  = 1'b0,
    EXTRA = 1'b1
  } fcs_state_t;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/ethernet_fcs_append_if.sv
// AXI-Stream flit bundle used between the egress stages.
//   tvalid/tready : handshake
//   tdata         : 32 byte lanes, lane 0 in bits [7:0]
//   tkeep         : one bit per lane, contiguous from lane 0
//   tlast         : final flit of a frame
// Handshake: a flit transfers on a rising clk edge where tvalid and tready are
// both 1; once tvalid is raised it stays high, with tdata/tkeep/tlast stable,
// until that transfer; tready may change freely.
interface axi_vif;
  import eth_pkg::*;

  logic                            tvalid;
  logic                            tready;
  logic [C_AXI_DATA_BYTES*8-1:0]   tdata;
  logic [C_AXI_DATA_BYTES-1:0]     tkeep;
  logic                            tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/crc32_lanes.sv
// Combinational CRC-32 over the kept byte lanes of one 32-byte flit.
//   crc_in  : running CRC register before this flit
//   data    : 32 byte lanes, lane 0 processed first
//   keep    : lane enables (lanes with keep=0 are skipped)
//   crc_out : running CRC register after this flit (not inverted)
module crc32_lanes
  import eth_pkg::*;
(
  input  logic [31:0]  crc_in,
  input  logic [255:0] data,
  input  logic [31:0]  keep,
  output logic [31:0]  crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 32; i++) begin
      if (keep[i]) c = crc32_byte(c, data[8*i +: 8]);
    end
    crc_out = c;
  end

endmodule

// File: rtl/ethernet_fcs_append.sv
// Appends the 4-byte Ethernet FCS after the last valid byte of each frame.
// Non-last flits pass through with zero latency; the last flit gets the FCS
// bytes written into the lanes after its data. If fewer than 4 lanes are free,
// the remaining FCS bytes go out in one extra flit (state EXTRA), during which
// the input is stalled.
//   clk, reset : clock, asynchronous active-high reset
//   in         : frames from the padding stage (slave side)
//   out        : frames with FCS appended (master side)
//   dbg_state  : current FSM state
module ethernet_fcs_append
  import eth_pkg::*;
#(
  parameter int          C_AXI_DATA_BYTES = 32,
  parameter logic [31:0] C_CRC_INIT       = 32'hFFFFFFFF
)
(
  input  logic       clk,
  input  logic       reset,
  axi_vif.slave      in,
  axi_vif.master     out,
  output fcs_state_t dbg_state
);

  generate
    if (C_AXI_DATA_BYTES != 32) begin : g_bad_width
      $error("ethernet_fcs_append supports only 32-byte flits");
    end
  endgenerate

  fcs_state_t    state_q, state_d;
  logic [31:0]   crc_q, crc_next, fcs;
  logic [31:0]   hold_data_q, hold_data_d;
  logic [3:0]    hold_keep_q, hold_keep_d;
  logic [5:0]    n_bytes;
  logic          spill;
  logic          in_hs;
  logic [31:0]   keep_short;
  logic [5:0]    rel;
  logic          o_valid, o_last, i_ready;
  logic [255:0]  o_data;
  logic [31:0]   o_keep;

  crc32_lanes u_crc (
    .crc_in  (crc_q),
    .data    (in.tdata),
    .keep    (in.tkeep),
    .crc_out (crc_next)
  );

  assign fcs = ~crc_next;

  always_comb begin
    n_bytes = '0;
    for (int i = 0; i < 32; i++) n_bytes = n_bytes + 6'(in.tkeep[i]);
  end

  // More than 28 data bytes leaves fewer than 4 free lanes for the FCS.
  assign spill      = (n_bytes > 6'd28);
  // (1 << (n+4)) - 1, valid for n <= 28.
  assign keep_short = 32'hFFFF_FFFF >> (6'd28 - n_bytes);
  // FCS bytes (32-n)..3 that did not fit, moved down to lane 0.
  assign hold_data_d = fcs >> {6'd32 - n_bytes, 3'b000};
  assign hold_keep_d = 4'hF >> (6'd32 - n_bytes);

  assign in_hs = in.tvalid && i_ready;

  always_comb begin
    state_d = state_q;
    o_valid = 1'b0;
    i_ready = 1'b0;
    o_data  = '0;
    o_keep  = '0;
    o_last  = 1'b0;
    rel     = '0;
    case (state_q)
      PASS: begin
        o_valid = in.tvalid && !reset;
        i_ready = out.tready && !reset;
        if (!in.tlast) begin
          o_data = in.tdata;
          o_keep = in.tkeep;
        end else begin
          for (int i = 0; i < 32; i++) begin
            rel = 6'(i) - n_bytes;
            if (6'(i) < n_bytes)  o_data[8*i +: 8] = in.tdata[8*i +: 8];
            else if (rel < 6'd4) o_data[8*i +: 8] = fcs[{rel[1:0], 3'b000} +: 8];
          end
          o_keep = spill ? '1 : keep_short;
          o_last = !spill;
          if (in.tvalid && out.tready && !reset && spill) state_d = EXTRA;
        end
      end
      EXTRA: begin
        o_valid       = !reset;
        o_data[31:0]  = hold_data_q;
        o_keep[3:0]   = hold_keep_q;
        o_last        = 1'b1;
        if (out.tready) state_d = PASS;
      end
      default: state_d = PASS;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= PASS;
      crc_q       <= C_CRC_INIT;
      hold_data_q <= '0;
      hold_keep_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == PASS && in_hs) begin
        if (in.tlast) begin
          crc_q <= C_CRC_INIT;
          if (spill) begin
            hold_data_q <= hold_data_d;
            hold_keep_q <= hold_keep_d;
          end
        end else begin
          crc_q <= crc_next;
        end
      end
    end
  end

  assign in.tready  = i_ready;
  assign out.tvalid = o_valid;
  assign out.tdata  = o_data;
  assign out.tkeep  = o_keep;
  assign out.tlast  = o_last;
  assign dbg_state  = state_q;

endmodule
